reset_clear_sequencer: RTL
==========================

// Module: reset_clear_sequencer
// PURPOSE
//  Parametrised successor to the single-source OSD reset/RAM-clear counter in the core top levels.
//  Merges NUM_SRC reset requests (OSD status bit, MiST buttons, board KEY, joystick fire, ...) into one core reset.
//  Runs an optional full-address memory clear sweep, then a fixed hold, and reports which source fired.
//  Sits in every core top level between user_io/arcade_inputs and the game core's reset input.
// PARAMETERS
//  NUM_SRC      4     number of reset request inputs (1..8)
//  CLR_AW       17    clear-sweep address width; sweep covers 0 .. 2**CLR_AW-1
//  HOLD_CYCLES  16    core_reset hold after sweep (>=1)
//  DEB_CYCLES   1024  debounce stability window (used only with RSTSEQ_DEBOUNCE_EN)
// PORTS
//  clk          in   1        system clock (PLL c0)
//  reset        in   1        asynchronous, active-high reset (e.g. PLL not locked)
//  src_req      in   NUM_SRC  level reset requests, asynchronous to clk
//  src_mask     in   NUM_SRC  1 = source enabled; sampled every cycle
//  clr_en       in   1        1 = run clear sweep; 0 = hold phase only
//  core_reset   out  1        active-high reset to game core
//  clr_we       out  1        write strobe for clear sweep (data is zero, owned by consumer)
//  clr_addr     out  CLR_AW   clear address
//  busy         out  1        high in any state except RUN
//  last_src     out  SRC_W    index of source that started the latest sequence; SRC_W = max(1,$clog2(NUM_SRC))
//  por_flag     out  1        1 while latest sequence was power-on, cleared by first source-triggered one
//  reset_count  out  8        saturating count of source-triggered sequences
// BEHAVIOUR
//  Reset values: core_reset=1, clr_we=0, clr_addr=0, busy=1, last_src=0, por_flag=1, reset_count=0; state=START.
//  Each src_req bit: 2-flop synchroniser; qualified request q = sync & src_mask (optionally debounced).
//  States:
//   START: core_reset=1, one cycle; -> CLEAR if clr_en else HOLD.
//   CLEAR: core_reset=1, clr_we=1, clr_addr increments by 1 per cycle from 0;
//          after the cycle writing 2**CLR_AW-1 -> HOLD, clr_addr returns to 0 (no wrap write).
//   HOLD:  core_reset=1, clr_we=0, down-counter HOLD_CYCLES; at expiry -> RUN.
//   RUN:   core_reset=0, busy=0. Any q bit high -> START.
//  Source entry (RUN->START): last_src = lowest-index active q bit; reset_count += 1 (saturates at 255); por_flag=0.
//  Request held in CLEAR/HOLD: sequence pinned -- clr_addr forced 0 (clr_we stays 1), hold counter reloaded;
//   the sweep restarts from 0 once released; counters and last_src are not updated again.
//  Latency (no debounce): src_req rise at input -> core_reset high within 3 clk edges from RUN.
//  clr_en changes are honoured only at START exit.
//  src_mask=0 on a bit: that source never triggers, even if already high.
//  reset asserted in any state: all outputs to reset values immediately (async); sweep restarts at 0 on release.
// CONFIGURATION
//  RSTSEQ_DEBOUNCE_EN defined: each synchronised bit must be stable for DEB_CYCLES consecutive cycles
//   before the debounced level changes (both edges); adds DEB_CYCLES latency.
//  Not defined: q uses the synchronised level directly; DEB_CYCLES unused, no counters built.
// STRUCTURE
//  Package rstseq_pkg: typedef enum logic [1:0] {ST_START, ST_CLEAR, ST_HOLD, ST_RUN}; RC_W=8 count width const.
//  Sub-module rstseq_debounce (one instance per source, generate loop): synchroniser + optional debounce counter.
//  Top: FSM, address counter, hold counter, priority encoder for last_src, saturating counter.
// TESTING
//  POR, CLR_AW=4, HOLD_CYCLES=16, clr_en=1: release reset -> clr_we high 16 cycles, addr 0..15, core_reset falls 16 cycles later; por_flag=1, reset_count=0.
//  In RUN, 1-cycle pulse src_req[1] -> core_reset high by 3rd edge, full 16-addr sweep, last_src=1, por_flag=0, reset_count=1.
//  src_req[0] held 40 cycles starting mid-CLEAR at addr 7 -> clr_addr stays 0 while held, then 0..15 sweep and hold; reset_count unchanged.
//  src_mask[2]=0 with src_req[2] pulsed -> no change; clr_en=0 then src_req[3] -> HOLD only, clr_we never high.
//  src_req[1] and [3] rise same cycle -> last_src=1; 256 triggered sequences -> reset_count saturates at 255.
//  reset asserted mid-HOLD -> outputs at reset values before next edge; with RSTSEQ_DEBOUNCE_EN, DEB_CYCLES=8: 5-cycle glitch ignored, 10-cycle pulse accepted.

Source files
------------

// File: rtl/rstseq_pkg.sv
// rstseq_pkg: shared state encoding and widths for the reset/clear sequencer
package rstseq_pkg;

    typedef enum logic [1:0] {ST_START, ST_CLEAR, ST_HOLD, ST_RUN} state_t;

    localparam int RC_W = 8;

endpackage

// File: rtl/rstseq_debounce.sv
// rstseq_debounce: two-flop synchroniser for one reset source, optionally debounced (RSTSEQ_DEBOUNCE_EN)
module rstseq_debounce #(
    parameter int DEB_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic lvl
);

    logic s1_q, s2_q;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("rstseq_debounce: DEB_CYCLES must be >= 1");
    end

    // bring the asynchronous request into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= req;
            s2_q <= s1_q;
        end
    end

`ifdef RSTSEQ_DEBOUNCE_EN
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;

    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire;

    assign expire = cnt_q == CW'(DEB_CYCLES - 1);

    // count consecutive cycles the synchronised level disagrees with the output; flip once the window is full
    always_comb begin
        lvl_d = (s2_q != lvl_q && expire) ? s2_q : lvl_q;
        cnt_d = (s2_q == lvl_q || expire) ? '0 : cnt_q + CW'(1);
    end

    // debounce state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = s2_q;
`endif

endmodule

// File: rtl/reset_clear_sequencer.sv
// reset_clear_sequencer: merges reset sources into a core reset with optional memory clear sweep and hold (RSTSEQ_DEBOUNCE_EN adds debounce)
module reset_clear_sequencer
    import rstseq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int CLR_AW      = 17,
    parameter int HOLD_CYCLES = 16,
    parameter int DEB_CYCLES  = 1024,
    localparam int SRC_W      = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic               clr_en,
    output logic               core_reset,
    output logic               clr_we,
    output logic [CLR_AW-1:0]  clr_addr,
    output logic               busy,
    output logic [SRC_W-1:0]   last_src,
    output logic               por_flag,
    output logic [RC_W-1:0]    reset_count
);

    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    if (NUM_SRC < 1 || NUM_SRC > 8 || CLR_AW < 1 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("reset_clear_sequencer: parameter out of range");
    end

    state_t             state_q, state_d;
    logic [CLR_AW-1:0]  addr_q, addr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SRC_W-1:0]   last_q, last_d;
    logic               por_q, por_d;
    logic [RC_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SRC-1:0] lvl, q;
    logic [SRC_W-1:0]   first_idx;
    logic               any_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        rstseq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .req   (src_req[i]),
            .lvl   (lvl[i])
        );
    end

    assign q     = lvl & src_mask;
    assign any_q = |q;

    // lowest-index active source wins when several fire together
    always_comb begin
        first_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (q[i]) first_idx = SRC_W'(i);
    end

    // sequencing: a request seen during CLEAR/HOLD pins that phase at its start
    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        hold_d  = (state_q != ST_HOLD || any_q) ? HW'(HOLD_CYCLES - 1) : hold_q - HW'(1);
        last_d  = last_q;
        por_d   = por_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_START: state_d = clr_en ? ST_CLEAR : ST_HOLD;
            ST_CLEAR: begin
                addr_d  = any_q ? '0 : addr_q + CLR_AW'(1);
                state_d = (!any_q && &addr_q) ? ST_HOLD : ST_CLEAR;
            end
            ST_HOLD:  state_d = (!any_q && hold_q == '0) ? ST_RUN : ST_HOLD;
            ST_RUN: begin
                if (any_q) begin
                    state_d = ST_START;
                    last_d  = first_idx;
                    por_d   = 1'b0;
                    cnt_d   = &cnt_q ? cnt_q : cnt_q + RC_W'(1);
                end
            end
        endcase
    end

    // sequencer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_START;
            addr_q  <= '0;
            hold_q  <= HW'(HOLD_CYCLES - 1);
            last_q  <= '0;
            por_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            por_q   <= por_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core_reset  = state_q != ST_RUN;
    assign busy        = state_q != ST_RUN;
    assign clr_we      = state_q == ST_CLEAR;
    assign clr_addr    = addr_q;
    assign last_src    = last_q;
    assign por_flag    = por_q;
    assign reset_count = cnt_q;

endmodule
